// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: count direction
// encodings, channel-index width helper and duty saturation.
package pwm_pkg;

    // Count directions used by the center-aligned (up/down) mode
    localparam logic CNT_UP   = 1'b0;
    localparam logic CNT_DOWN = 1'b1;

    // Channel index width: clog2(channels), never narrower than one bit
    function automatic int ch_width(input int channels);
        int w;
        if (channels > 1) begin
            w = $clog2(channels);
        end else begin
            w = 1;
        end
        return w;
    endfunction

    // Clamp a duty request to 2^width, the value that means 100 % on time
    function automatic logic [31:0] duty_sat(input logic [31:0] duty, input int width);
        logic [31:0] limit_v;
        limit_v = 32'd1 << width;
        if (duty > limit_v) begin
            return limit_v;
        end else begin
            return duty;
        end
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Shared prescaler: emits a one-cycle tick every prescale+1 clock cycles
// while enabled; held at zero while disabled so a restart is aligned.
module pwm_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_cnt_r;
    logic                  tick_s;

    // Tick when the count reaches (or, after a live decrease, passes) prescale
    always_comb begin
        tick_s = 1'b0;
        if (ena && (pre_cnt_r >= prescale)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Prescale counter: cleared when disabled or on tick, otherwise counts up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_r <= '0;
        end else if (!ena) begin
            pre_cnt_r <= '0;
        end else if (tick_s) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_r + PRESCALE_W'(1);
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator. One shared prescaler and period counter drive
// CHANNELS comparators with double-buffered duty values that swap in at the
// period boundary. Optional center-aligned counting is built only when the
// macro PWM_CENTER_EN is defined; otherwise the block is edge-aligned only.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int CHANNELS   = 4,
    parameter  int PRESCALE_W = 16,
    localparam int CH_W       = ch_width(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  center_mode,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [WIDTH:0]        wr_duty,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_start
);

    localparam int                DW       = WIDTH + 1;
    localparam logic [WIDTH-1:0]  CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(CHANNELS);

    logic                tick_s;
    logic                boundary_s;
    logic [WIDTH-1:0]    cnt_r;
    logic [WIDTH-1:0]    cnt_nxt_s;
    logic                wr_ok_s;
    logic [DW-1:0]       wr_sat_s;
    logic [DW-1:0]       shadow_r     [CHANNELS];
    logic [DW-1:0]       shadow_nxt_s [CHANNELS];
    logic [DW-1:0]       active_r     [CHANNELS];
    logic [CHANNELS-1:0] pwm_r;
    logic                period_start_r;

    pwm_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .prescale (prescale),
        .tick     (tick_s)
    );

`ifdef PWM_CENTER_EN
    logic dir_r;
    logic dir_nxt_s;
    logic mode_r;

    // Next count: up/down triangle when center mode is latched, else sawtooth
    always_comb begin
        cnt_nxt_s  = cnt_r;
        dir_nxt_s  = dir_r;
        boundary_s = 1'b0;
        if (!tick_s) begin
            cnt_nxt_s = cnt_r;
        end else if (mode_r) begin
            if (dir_r == CNT_UP) begin
                if (cnt_r == CNT_MAX) begin
                    dir_nxt_s = CNT_DOWN;
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end else begin
                if (cnt_r == CNT_ONE) begin
                    dir_nxt_s  = CNT_UP;
                    cnt_nxt_s  = '0;
                    boundary_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
        end else begin
            dir_nxt_s  = CNT_UP;
            cnt_nxt_s  = cnt_r + CNT_ONE;
            boundary_s = (cnt_r == CNT_MAX);
        end
    end

    // Direction state; counting mode is only re-sampled at a boundary or while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_r  <= CNT_UP;
            mode_r <= 1'b0;
        end else if (!ena) begin
            dir_r  <= CNT_UP;
            mode_r <= center_mode;
        end else begin
            dir_r <= dir_nxt_s;
            if (boundary_s) begin
                mode_r <= center_mode;
            end else begin
                mode_r <= mode_r;
            end
        end
    end
`else
    logic unused_center_s;
    assign unused_center_s = center_mode;

    // Next count: edge-aligned sawtooth, boundary on the wrap from max to zero
    always_comb begin
        cnt_nxt_s  = cnt_r;
        boundary_s = 1'b0;
        if (tick_s) begin
            cnt_nxt_s  = cnt_r + CNT_ONE;
            boundary_s = (cnt_r == CNT_MAX);
        end else begin
            cnt_nxt_s  = cnt_r;
            boundary_s = 1'b0;
        end
    end
`endif

    // Period counter, parked at zero while disabled so a restart begins at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (!ena) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // Write decode, saturation, and the shadow values after this cycle's write
    always_comb begin
        wr_ok_s  = 1'b0;
        wr_sat_s = DW'(duty_sat(32'(wr_duty), WIDTH));
        if (wr_en && ({1'b0, wr_ch} < CH_LIMIT)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_ok_s && (wr_ch == CH_W'(i))) begin
                shadow_nxt_s[i] = wr_sat_s;
            end else begin
                shadow_nxt_s[i] = shadow_r[i];
            end
        end
    end

    // Shadow registers take writes at any time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_r[i] <= shadow_nxt_s[i];
            end
        end
    end

    // Active duties swap in at a boundary (including a coincident write) or track while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                active_r[i] <= '0;
            end
        end else if (!ena || boundary_s) begin
            for (int i = 0; i < CHANNELS; i++) begin
                active_r[i] <= shadow_nxt_s[i];
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                active_r[i] <= active_r[i];
            end
        end
    end

    // Registered comparators and period pulse; compare is one bit wider than cnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_r          <= '0;
            period_start_r <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_r[i] <= ena && ({1'b0, cnt_r} < active_r[i]);
            end
            period_start_r <= boundary_s;
        end
    end

    assign pwm_out      = pwm_r;
    assign period_start = period_start_r;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: WIDTH=4, prescale=0 unless changed.
// Three channels so that a 2-bit wr_ch can address a non-existent channel 3.
module tb_pwm_multi_ch;

    localparam int WIDTH      = 4;
    localparam int CHANNELS   = 3;
    localparam int PRESCALE_W = 16;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [15:0] prescale;
    logic        center_mode;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [4:0]  wr_duty;
    logic [2:0]  pwm_out;
    logic        period_start;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int hi0, hi1, hi2, ps_cnt, ps_idx, found, per_len;
    logic [2:0] first_vec;

    pwm_multi_ch #(
        .WIDTH      (WIDTH),
        .CHANNELS   (CHANNELS),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .prescale     (prescale),
        .center_mode  (center_mode),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // one write strobe, called at a negedge; returns at the following negedge
    task automatic write(input logic [1:0] ch, input logic [4:0] duty);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_duty = duty;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // sample n negedges, counting high cycles per channel and period pulses
    task automatic measure(input int n);
        hi0 = 0; hi1 = 0; hi2 = 0; ps_cnt = 0; ps_idx = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 1) first_vec = pwm_out;
            hi0 += int'(pwm_out[0]);
            hi1 += int'(pwm_out[1]);
            hi2 += int'(pwm_out[2]);
            if (period_start) begin
                ps_cnt++;
                if (ps_idx == 0) ps_idx = i;
            end
        end
    endtask

    // sample until period_start (bounded); per_len = samples taken, hi0 = ch0 highs
    task automatic wait_ps(input string tag);
        found = 0; per_len = 0; hi0 = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            per_len++;
            hi0 += int'(pwm_out[0]);
            if (period_start) found = 1;
        end
        check({tag, "_ps_seen"}, found, 1);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; prescale = 16'd0; center_mode = 1'b0;
        wr_en = 1'b0; wr_ch = 2'd0; wr_duty = 5'd0;
        repeat (3) @(negedge clk);
        check("reset_pwm", pwm_out, 3'b000);
        check("reset_ps", period_start, 1'b0);

        // running with no duties written: no pulses, period pulses every 16
        rst_n = 1'b1; ena = 1'b1;
        measure(40);
        check("idle_ch0", hi0, 0);
        check("idle_ch1", hi1, 0);
        check("idle_ps_cnt", ps_cnt, 2);
        check("idle_ps_idx", ps_idx, 16);

        // ch0=4, ch1=16 (100 %)
        write(2'd0, 5'd4);
        write(2'd1, 5'd16);
        wait_ps("w1");
        measure(16);
        check("w1_ch0_hi", hi0, 4);
        check("w1_ch1_hi", hi1, 16);
        check("w1_first", first_vec, 3'b011);
        check("w1_ps_idx", ps_idx, 16);
        measure(16);
        check("w1b_ch0_hi", hi0, 4);
        check("w1b_ps_cnt", ps_cnt, 1);

        // ch0=8 written mid-period: old duty holds to the boundary
        repeat (6) @(negedge clk);
        write(2'd0, 5'd8);
        wait_ps("mid");
        check("mid_old_tail", hi0, 0);
        measure(16);
        check("mid_ch0_hi", hi0, 8);
        check("mid_ch1_hi", hi1, 16);

        // ch0=0: constantly low
        write(2'd0, 5'd0);
        wait_ps("zero");
        measure(16);
        check("zero_ch0_hi", hi0, 0);
        check("zero_ch1_hi", hi1, 16);

        // prescale=2, ch0=4: 48-cycle period, 12 high
        write(2'd0, 5'd4);
        prescale = 16'd2;
        wait_ps("pre");
        wait_ps("pre_period");
        check("pre_period_len", per_len, 48);
        check("pre_ch0_hi", hi0, 12);
        prescale = 16'd0;
        wait_ps("pre_back");

        // write to channel 3 (does not exist) changes nothing
        write(2'd3, 5'd8);
        wait_ps("badch");
        measure(16);
        check("badch_ch0_hi", hi0, 4);
        check("badch_ch1_hi", hi1, 16);
        check("badch_ch2_hi", hi2, 0);
        check("badch_ps_idx", ps_idx, 16);

        // write landing on the boundary clock edge goes straight to active
        repeat (15) @(negedge clk);
        write(2'd0, 5'd2);
        check("wt_ps_at_write", period_start, 1'b1);
        measure(16);
        check("wt_ch0_hi", hi0, 2);

        // drop ena mid-period
        repeat (3) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        check("ena_low_pwm", pwm_out, 3'b000);
        check("ena_low_ps", period_start, 1'b0);
        write(2'd1, 5'd5);
        write(2'd0, 5'd6);
        measure(10);
        check("dis_ch0_hi", hi0, 0);
        check("dis_ch1_hi", hi1, 0);
        check("dis_ps_cnt", ps_cnt, 0);

        // re-enable: period restarts at cnt=0 with the latest duties
        ena = 1'b1;
        measure(16);
        check("reen_first", first_vec, 3'b011);
        check("reen_ch0_hi", hi0, 6);
        check("reen_ch1_hi", hi1, 5);
        check("reen_ps_idx", ps_idx, 16);

        // asynchronous reset mid-run
        repeat (2) @(negedge clk);
        check("pre_rst_pwm", pwm_out, 3'b011);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_pwm", pwm_out, 3'b000);
        check("rst_async_ps", period_start, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        measure(40);
        check("post_rst_ch0", hi0, 0);
        check("post_rst_ch1", hi1, 0);
        check("post_rst_ps_idx", ps_idx, 16);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
